serial_sub_n: RTL and testbench

- Bit-serial N-bit subtractor that computes diff = a - b, one bit per clock, LSB first, using a single full-subtractor cell.
- It is the sequential, subtracting counterpart to the combinational ripple adders in the arithmetic library.
- It is used where area matters more than latency, for example in multi-cycle datapaths.
- Operands are accepted with a start/busy/done handshake. Results are held stable until the next operation completes.

---
 rtl/serial_sub_n.sv | 108 ++++++++++
 tb/tb_serial_sub_n.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_sub_n.sv
// Bit-serial N-bit subtractor: diff = a - b, one bit per clock, LSB first,
// with a start/busy/done handshake and held results.
module serial_sub_n #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] diff,
   output logic         borrow,
   output logic         ovf
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | one difference bit per edge, N edges
   // DONE  | results just loaded, done pulse, ready for back-to-back start

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [N-1:0]  sh_a, sh_b, part, part_nx;
   logic [CW-1:0] cnt;
   logic          br, br_nx, d_bit;
   logic          a_msb, b_msb;
   logic          ready, accept, last;

   assign ready  = (state == IDLE) || (state == DONE);
   assign accept = ready && start;
   assign last   = (state == RUN) && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = start ? RUN : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Full-subtractor cell; the new bit enters the partial result at the MSB end.
   always_comb begin
      d_bit      = sh_a[0] ^ sh_b[0] ^ br;
      br_nx      = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);
      part_nx    = part >> 1;
      part_nx[N-1] = d_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a   <= '0;
         sh_b   <= '0;
         part   <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         ovf    <= 1'b0;
      end else if (accept) begin
         sh_a  <= a;
         sh_b  <= b;
         part  <= '0;
         cnt   <= '0;
         br    <= 1'b0;
         a_msb <= a[N-1];
         b_msb <= b[N-1];
      end else if (state == RUN) begin
         sh_a <= sh_a >> 1;
         sh_b <= sh_b >> 1;
         part <= part_nx;
         br   <= br_nx;
         cnt  <= cnt + 1'b1;
         if (last) begin
            diff   <= part_nx;
            borrow <= br_nx;
            ovf    <= (a_msb != b_msb) && (part_nx[N-1] != a_msb);
         end
      end
   end

endmodule

// File: tb/tb_serial_sub_n.sv
// Directed bench for serial_sub_n: N=8 instance plus an N=1 instance.
module tb_serial_sub_n;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0, start1 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       busy8, done8, borrow8, ovf8;
   logic [7:0] diff8;
   logic       busy1, done1, borrow1, ovf1;
   logic [0:0] diff1;
   int         n_chk = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   serial_sub_n #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
   );

   serial_sub_n #(.N(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .ovf(ovf1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits for done on the N=8 instance, counting busy cycles on the way.
   task automatic wait_done8(output int cyc, output int nb);
      cyc = 0;
      nb  = 0;
      while (!done8 && cyc < 30) begin
         if (busy8) nb++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic eb, input logic eo);
      int cyc, nb;
      @(negedge clk);
      start8 = 1'b1; a8 = a; b8 = b;
      @(negedge clk);
      start8 = 1'b0;
      a8 = ~a; b8 = 8'h5a;
      wait_done8(cyc, nb);
      chk("lat8", cyc, 8);
      chk("busy_cycles8", nb, 8);
      chk("done_busy8", busy8, 0);
      chk("diff8", diff8, ed);
      chk("borrow8", borrow8, eb);
      chk("ovf8", ovf8, eo);
      @(negedge clk);
      chk("done_pulse8", done8, 0);
      chk("diff_hold8", diff8, ed);
      chk("borrow_hold8", borrow8, eb);
      chk("ovf_hold8", ovf8, eo);
   endtask

   task automatic op1(input logic a, input logic b,
                      input logic ed, input logic eb, input logic eo);
      int cyc;
      @(negedge clk);
      start1 = 1'b1; a1 = a; b1 = b;
      @(negedge clk);
      start1 = 1'b0;
      chk("busy1", busy1, 1);
      cyc = 0;
      while (!done1 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      chk("lat1", cyc, 1);
      chk("diff1", diff1, ed);
      chk("borrow1", borrow1, eb);
      chk("ovf1", ovf1, eo);
   endtask

   initial begin
      int cyc, nb;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_diff", diff8, 0);
      chk("rst_borrow", borrow8, 0);
      chk("rst_ovf", ovf8, 0);
      rst_n = 1'b1;
      @(negedge clk);

      op8(8'd200, 8'd55, 8'd145, 1'b0, 1'b0);
      op8(8'd5,   8'd10, 8'd251, 1'b1, 1'b0);
      op8(8'h80,  8'h01, 8'h7f,  1'b0, 1'b1);
      op8(8'h7f,  8'hff, 8'h80,  1'b1, 1'b1);

      // Start pulse during RUN is ignored; then back-to-back from DONE.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8(cyc, nb);
      chk("mid_lat", cyc, 4);
      chk("mid_diff", diff8, 8'd6);
      chk("mid_borrow", borrow8, 0);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      chk("b2b_busy", busy8, 1);
      wait_done8(cyc, nb);
      chk("b2b_lat", cyc + 1, 9);
      chk("b2b_diff", diff8, 8'd0);
      chk("b2b_borrow", borrow8, 0);
      chk("b2b_ovf", ovf8, 0);

      // Leave nonzero held results, then reset asynchronously mid-RUN.
      op8(8'h7f, 8'hff, 8'h80, 1'b1, 1'b1);
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd100; b8 = 8'd1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", busy8, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy8, 0);
      chk("arst_done", done8, 0);
      chk("arst_diff", diff8, 0);
      chk("arst_borrow", borrow8, 0);
      chk("arst_ovf", ovf8, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nb = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done8 || busy8) nb++;
      end
      chk("post_rst_quiet", nb, 0);
      op8(8'd100, 8'd1, 8'd99, 1'b0, 1'b0);

      op1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      op1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      op1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      op1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
